// File: rtl/dual_port_ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (sync write, async read).
// Wrap-bit pointers give full/empty; ready/valid/almost_full come from registers only.
module dual_port_ram_fifo_ctrl #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 2,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_q;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign almost_full = (count_q >= AFULL_CNT);
    assign count       = count_q;

    // flush suppresses both handshakes so nothing is written in the clearing cycle
    assign push = in_valid && !full && !flush;
    assign pop  = out_ready && !empty && !flush;

    assign ram_we      = push;
    assign ram_addr_wr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_din     = in_data;
    assign ram_addr_rd = rd_ptr[ADDR_WIDTH-1:0];
    assign out_data    = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
